// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall/flush control and MEM/WB operand forwarding
// into the execute-stage ALU inputs.
module id_ex_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [3:0]        id_aluctl,
    input  logic              id_alusrc,
    input  logic              id_regwrite,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_wrreg,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] mem_wrreg,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] wb_wrreg,
    input  logic [DATA_W-1:0] wb_result,
    output logic              ex_valid,
    output logic [3:0]        ex_aluctl,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_store_data,
    output logic              ex_regwrite,
    output logic [REG_AW-1:0] ex_wrreg
);

    localparam int unsigned CTL_W = 4;

    typedef struct packed {
        logic              valid;
        logic [CTL_W-1:0]  aluctl;
        logic              alusrc;
        logic              regwrite;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] wrreg;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
    } ex_fields_t;

    ex_fields_t ex_q;
    ex_fields_t ex_d;
    logic       wb_live;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    assign wb_live = wb_regwrite && (wb_wrreg != REG_AW'(0));

    // Next-state select: flush beats stall beats load; reset handled in the register.
    always_comb begin
        ex_d = ex_q;
        if (flush) begin
            ex_d = '0;
        end else if (stall) begin
            // A held operand must absorb a WB write that retires while we wait.
            if (wb_live && (ex_q.rs == wb_wrreg)) ex_d.rs_data = wb_result;
            if (wb_live && (ex_q.rt == wb_wrreg)) ex_d.rt_data = wb_result;
        end else begin
            ex_d.valid    = id_valid;
            ex_d.aluctl   = id_aluctl;
            ex_d.alusrc   = id_alusrc;
            ex_d.regwrite = id_regwrite;
            ex_d.rs       = id_rs;
            ex_d.rt       = id_rt;
            ex_d.wrreg    = id_wrreg;
            ex_d.rs_data  = id_rs_data;
            ex_d.rt_data  = id_rt_data;
            ex_d.imm      = id_imm;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ex_q <= '0;
        else        ex_q <= ex_d;
    end

    // Same-cycle forwarding, MEM ahead of WB; register 0 is never forwarded.
    always_comb begin
        fwd_rs = ex_q.rs_data;
        fwd_rt = ex_q.rt_data;
        if (ex_q.rs != REG_AW'(0)) begin
            if (mem_regwrite && (mem_wrreg == ex_q.rs))     fwd_rs = mem_result;
            else if (wb_regwrite && (wb_wrreg == ex_q.rs))  fwd_rs = wb_result;
        end
        if (ex_q.rt != REG_AW'(0)) begin
            if (mem_regwrite && (mem_wrreg == ex_q.rt))     fwd_rt = mem_result;
            else if (wb_regwrite && (wb_wrreg == ex_q.rt))  fwd_rt = wb_result;
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_aluctl     = ex_q.aluctl;
    assign ex_wrreg      = ex_q.wrreg;
    assign ex_regwrite   = ex_q.regwrite & ex_q.valid;
    assign ex_a          = fwd_rs;
    assign ex_b          = ex_q.alusrc ? ex_q.imm : fwd_rt;
    assign ex_store_data = fwd_rt;

endmodule
